// File: rtl/fibonacci_gen.sv
// rtl/fibonacci_gen.sv - free-running Fibonacci term generator with restart or saturate on overflow
//
// Purpose:
//   Steps through F(0), F(1), F(2), ... one term per rising clk edge. When the next
//   term would not fit in WIDTH bits, the generator either restarts at F(0) or
//   saturates on the largest representable term.
//
// Configuration:
//   FIBONACCI_SATURATE_EN - when defined, overflow freezes the sequence on its
//                           largest term and holds wrap high until reset.
//                           When undefined, overflow restarts the sequence and
//                           pulses wrap for a single cycle.
//
// Ports:
//   clk    in   1      sole clock, rising-edge active
//   reset  in   1      asynchronous, active-high reset
//   out    out  WIDTH  current term F(n), registered
//   idx    out  6      index n of the term on out, registered
//   wrap   out  1      overflow flag, registered
//
// Parameters:
//   WIDTH  term width, legal range 2..32. At WIDTH=32 the largest index is 47,
//          so 6 bits of idx are always enough.

module fibonacci_gen #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out,
  output logic [5:0]       idx,
  output logic             wrap
);

  // prev starts at F(-1) = 1, so the first advance yields 0 + 1 = F(1).
  localparam logic [WIDTH-1:0] PREV_INIT = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cur_q;
  logic [WIDTH-1:0] prev_q;
  logic [5:0]       idx_q;
  logic             wrap_q;

  // One extra bit: the carry tells us the next term no longer fits in WIDTH bits.
  logic [WIDTH:0]   sum_d;

  assign sum_d = {1'b0, cur_q} + {1'b0, prev_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q  <= '0;
      prev_q <= PREV_INIT;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else if (!sum_d[WIDTH]) begin
      cur_q  <= sum_d[WIDTH-1:0];
      prev_q <= cur_q;
      idx_q  <= idx_q + 6'd1;
      wrap_q <= 1'b0;
    end else begin
`ifdef FIBONACCI_SATURATE_EN
      // Hold the largest term. The carry recurs on every later edge,
      // so wrap stays high until reset.
      cur_q  <= cur_q;
      prev_q <= prev_q;
      idx_q  <= idx_q;
      wrap_q <= 1'b1;
`else
      // Restart exactly as reset leaves it, so the edge after wrap produces F(1).
      cur_q  <= '0;
      prev_q <= PREV_INIT;
      idx_q  <= '0;
      wrap_q <= 1'b1;
`endif
    end
  end

  assign out  = cur_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_fibonacci_gen.sv
// tb/tb_fibonacci_gen.sv - directed self-checking bench for fibonacci_gen (WIDTH=17 and WIDTH=8)
module tb_fibonacci_gen;

`ifdef FIBONACCI_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [16:0] out17;
  logic [5:0]  idx17;
  logic        wrap17;
  logic [7:0]  out8;
  logic [5:0]  idx8;
  logic        wrap8;

  int checks;
  int failures;

  // Hand-computed F(0)..F(26).
  int unsigned fib [0:26] = '{
    0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987,
    1597, 2584, 4181, 6765, 10946, 17711, 28657, 46368, 75025, 121393
  };

  fibonacci_gen #(.WIDTH(17)) dut17 (
    .clk   (clk),
    .reset (reset),
    .out   (out17),
    .idx   (idx17),
    .wrap  (wrap17)
  );

  fibonacci_gen #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .out   (out8),
    .idx   (idx8),
    .wrap  (wrap8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk17(input string tag, input int unsigned o, input int unsigned i, input bit w);
    chk({tag, " out17"},  {15'd0, out17}, o);
    chk({tag, " idx17"},  {26'd0, idx17}, i);
    chk({tag, " wrap17"}, {31'd0, wrap17}, {31'd0, w});
  endtask

  task automatic chk8(input string tag, input int unsigned o, input int unsigned i, input bit w);
    chk({tag, " out8"},  {24'd0, out8}, o);
    chk({tag, " idx8"},  {26'd0, idx8}, i);
    chk({tag, " wrap8"}, {31'd0, wrap8}, {31'd0, w});
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held high across several edges: outputs stay at the reset state.
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk17($sformatf("reset_hold%0d", k), 0, 0, 1'b0);
      chk8($sformatf("reset_hold%0d", k), 0, 0, 1'b0);
    end

    // Release between edges, then run 28 edges through overflow on both widths.
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 28; e++) begin
      @(posedge clk);
      #1;
      if (e <= 26)
        chk17($sformatf("run17_e%0d", e), fib[e], e, 1'b0);
      else if (SAT)
        chk17($sformatf("sat17_e%0d", e), 121393, 26, 1'b1);
      else if (e == 27)
        chk17("wrap17_e27", 0, 0, 1'b1);
      else
        chk17("restart17_e28", 1, 1, 1'b0);

      if (e <= 13)
        chk8($sformatf("run8_e%0d", e), fib[e], e, 1'b0);
      else if (SAT)
        chk8($sformatf("sat8_e%0d", e), 233, 13, 1'b1);
      else if (e % 14 == 0)
        chk8($sformatf("wrap8_e%0d", e), 0, 0, 1'b1);
      else
        chk8($sformatf("run8_e%0d", e), fib[e % 14], e % 14, 1'b0);
    end

    // Asynchronous reset away from any edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk17("async_rst_a", 0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Run up to out17=233, then assert reset mid-cycle.
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk);
      #1;
      chk17($sformatf("rerun17_e%0d", e), fib[e], e, 1'b0);
    end
    #2;
    reset = 1'b1;
    #1;
    chk17("async_rst_at233", 0, 0, 1'b0);
    chk8("async_rst_at233", 0, 0, 1'b0);
    @(posedge clk);
    #1;
    chk17("rst_held_edge", 0, 0, 1'b0);

    // After release the sequence restarts at 1,1,2.
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      chk17($sformatf("post_rst_e%0d", e), fib[e], e, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
